// File: rtl/pb_pkg.sv
// pb_pkg: constants shared by the pushbutton conditioner and the I/O driver address map.
`default_nettype none

package pb_pkg;

    localparam int NUM_PB       = 21;
    localparam int PB_BASE_ADDR = 10;
    localparam int SYNC_DEPTH   = 2;

endpackage

`default_nettype wire

// File: rtl/pb_debounce_cell.sv
// ============================================================================
// pb_debounce_cell: one button - 2-flop synchroniser, tick-sampled window,
// debounced level and, with PB_STICKY_EN defined, a press-latching sticky bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pb_debounce_cell
    import pb_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_raw,
    input  logic i_tick,
    input  logic i_clr,
    output logic o_pb,
    output logic o_level
);

    logic [SYNC_DEPTH-1:0]     r_sync;
    logic [STABLE_SAMPLES-2:0] r_win;
    logic [STABLE_SAMPLES-1:0] w_next_win;
    logic                      r_lvl;

    // Level decision looks at the window including the sample taken this tick.
    assign w_next_win = {r_win, r_sync[SYNC_DEPTH-1]};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync <= '0;
            r_win  <= '0;
            r_lvl  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_raw};
            if (i_tick) begin
                r_win <= w_next_win[STABLE_SAMPLES-2:0];
                if (&w_next_win) begin
                    r_lvl <= 1'b1;
                end else if (~|w_next_win) begin
                    r_lvl <= 1'b0;
                end
            end
        end
    end

    assign o_level = r_lvl;

`ifdef PB_STICKY_EN
    logic r_lvl_d;
    logic r_sticky;

    // A rising level sets the bit one cycle later; set beats a coincident read clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_lvl_d  <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_lvl_d <= r_lvl;
            if (r_lvl && !r_lvl_d) begin
                r_sticky <= 1'b1;
            end else if (i_clr) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign o_pb = r_lvl | r_sticky;
`else
    logic w_unused_clr;
    assign w_unused_clr = i_clr;
    assign o_pb         = r_lvl;
`endif

endmodule

`default_nettype wire

// File: rtl/pb_conditioner.sv
// ============================================================================
// pb_conditioner: synchronises and debounces the pushbutton bank against a
// shared sample tick. Optional press latching under macro PB_STICKY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pb_conditioner
    import pb_pkg::*;
#(
    parameter int NUM_PB         = pb_pkg::NUM_PB,
    parameter int TICK_DIV       = 50000,
    parameter int STABLE_SAMPLES = 4,
    parameter int PB_BASE        = PB_BASE_ADDR
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NUM_PB-1:0] pb_raw,
    input  logic              read_en,
    input  logic [7:0]        addr,
    output logic [NUM_PB-1:0] pb,
    output logic [NUM_PB-1:0] pb_level,
    output logic              any_pb
);

    localparam int                CNT_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]  r_div_cnt;
    logic              w_tick;
    logic [NUM_PB-1:0] w_clr;

    assign w_tick = (r_div_cnt == C_TICK_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_pb
            // Compare in int so a base near the top of the page cannot alias.
            assign w_clr[gi] = read_en && (int'(addr) == PB_BASE + gi);

            pb_debounce_cell #(
                .STABLE_SAMPLES(STABLE_SAMPLES)
            ) u_cell (
                .clk     (clk),
                .nrst    (nrst),
                .i_raw   (pb_raw[gi]),
                .i_tick  (w_tick),
                .i_clr   (w_clr[gi]),
                .o_pb    (pb[gi]),
                .o_level (pb_level[gi])
            );
        end
    endgenerate

    assign any_pb = |pb;

endmodule

`default_nettype wire

// File: doc/pb_conditioner.md
Name: pb_conditioner

Overview:
- Upstream conditioning stage for the memory-mapped pushbutton bank.
- Takes the 21 raw, asynchronous FPGA pushbutton inputs and synchronises each one into the clk domain, then debounces it against a shared sample tick.
- Drives the pb[20:0] vector that the I/O driver returns on CPU reads of the button addresses.
- Can optionally latch presses, so a short press is not missed between CPU polls.

Parameters:
- NUM_PB, 21: number of buttons.
- TICK_DIV, 50000: clk cycles per debounce sample tick; must be >= 2.
- STABLE_SAMPLES, 4: consecutive identical samples needed to change the debounced level; must be >= 2.
- PB_BASE, 10: page-relative address of button 0; button i is at PB_BASE+i.

Ports:
- clk, input, 1: system clock.
- nrst, input, 1: asynchronous active-low reset.
- pb_raw, input, NUM_PB: raw pushbutton pins, asynchronous.
- read_en, input, 1: CPU bus read qualifier; high means a read cycle.
- addr, input, 8: page-relative bus address.
- pb, output, NUM_PB: conditioned button vector, fed to the I/O driver.
- pb_level, output, NUM_PB: debounced level, with no latching.
- any_pb, output, 1: OR-reduction of pb.

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is asynchronous and active-low. While nrst=0 every flop clears:
  - sync stages, prescaler, sample shift registers, debounced levels and sticky bits all go to 0;
  - pb, pb_level and any_pb therefore read 0.
  - Reset asserted mid-debounce discards partial history. After release, a held button must re-qualify from scratch.
- Synchroniser: a 2-flop chain per bit gives sync_i. No logic reads the first stage.
- Prescaler:
  - Counter counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly the one cycle in which the count equals TICK_DIV-1.
  - The counter is shared by all buttons and runs freely from reset.
- Sampling (per button i, on each tick edge):
  - win_i <= {win_i[STABLE_SAMPLES-2:0], sync_i}.
  - In the same edge, lvl_i is evaluated on the incoming window {win_i[STABLE_SAMPLES-2:0], sync_i}:
    - all ones: lvl_i <= 1;
    - all zeros: lvl_i <= 0;
    - otherwise lvl_i holds.
  - No update on non-tick cycles.
- pb_level = lvl, a registered output.
- Latency from a raw change to lvl: 2 sync edges, then the next tick (1..TICK_DIV edges), then STABLE_SAMPLES-1 further ticks. Total edge count = 2 + [1..TICK_DIV] + (STABLE_SAMPLES-1)*TICK_DIV.
- Glitch rejection: a pulse sampled by fewer than STABLE_SAMPLES consecutive ticks never changes lvl.
- Without the optional feature:
  - pb = lvl;
  - read_en and addr are ignored.
- any_pb is combinational from pb.

Optional Feature:
- Macro: PB_STICKY_EN.
- Defined:
  - Each button gets a sticky_i flop.
  - Set condition: sticky_i sets on the cycle after lvl_i rises, detected as lvl_i=1 and lvl_d_i=0, where lvl_d_i is a registered copy of lvl_i.
  - Clear condition: sticky_i clears on any clk edge where read_en=1 and addr==PB_BASE+i.
  - Set and clear on the same cycle: set wins, so the new press is kept.
  - pb = lvl | sticky. The read that observes a press therefore returns 1, and the bit clears on the following edge if the button has been released.
  - A read of an address outside PB_BASE..PB_BASE+NUM_PB-1 clears nothing.
  - A clear in the same cycle as the button being held has no visible effect, because lvl keeps pb high.
- Undefined:
  - No sticky or lvl_d flops exist; pb = lvl.

Decomposition:
- Package pb_pkg holds:
  - NUM_PB;
  - PB_BASE_ADDR (10), shared with the I/O driver's address map;
  - the sync depth constant (2).
- Sub-module pb_debounce_cell: per-button synchroniser, window, level and (optionally) sticky logic. Its inputs are tick and a clear strobe.
- The top level holds the prescaler, the address compare that forms the per-button clear strobe, a generate loop over NUM_PB, and the any_pb reduction.

Test Plan:
All scenarios use TICK_DIV=4 and STABLE_SAMPLES=3.
1. Reset: drive pb_raw=all ones and hold nrst=0 for 10 cycles -> pb=0, pb_level=0, any_pb=0 throughout. Release reset -> pb[i] rises 11..14 edges after release, not before.
2. Clean press: pb_raw[5] 0->1 and held 40 cycles -> pb_level[5]=1 within 11..14 edges and any_pb=1. Release -> pb_level[5]=0 within 11..14 edges. No other bit toggles.
3. Glitch: pb_raw[0] high for 5 cycles, then low -> pb_level[0] stays 0 throughout. Also bounce pattern 1,0,1,0 at one change per 3 cycles, then steady 1 -> exactly one rising transition.
4. Sticky (PB_STICKY_EN): press button 20 for 16 cycles, release, wait 40 cycles -> pb[20]=1 held after release. Assert read_en=1, addr=30 for 1 cycle -> pb[20]=1 during the read, 0 on the next cycle.
5. Set/clear collision (PB_STICKY_EN): schedule read_en=1, addr=10 on the exact cycle sticky[0] is set -> pb[0] remains 1 after that cycle. A read of addr=31 leaves all sticky bits unchanged.
6. Mid-operation reset: pb_raw[3]=1, then pulse nrst low for 1 cycle after 2 ticks -> pb_level[3] rises only 11..14 edges after reset release.
